// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU control-unit slice.
package cpu_ctrl_pkg;

  localparam int NREGS_DEFAULT = 16;
  localparam int IDXW_DEFAULT  = 4;
  localparam int R0_IDX        = 0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    CAPTURE,
    DONE
  } state_t;

  // States in which the source register is driving the shared bus.
  function automatic logic drives_bus(input state_t s);
    return (s == SETUP) || (s == WAIT) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/bus_xfer_sequencer_if.sv
// Request handshake plus register-file enables of the transfer sequencer.
interface bus_xfer_sequencer_if
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int IDXW  = IDXW_DEFAULT
);
  logic             req_valid;
  logic             req_ready;
  logic [IDXW-1:0]  req_src;
  logic [IDXW-1:0]  req_dst;
  logic             req_use_ba;
  logic [NREGS-1:0] Rout;
  logic [NREGS-1:0] Rin;
  logic             BAout;
  logic             busy;
  logic             done;

  modport master (
    output req_valid, req_src, req_dst, req_use_ba,
    input  req_ready, Rout, Rin, BAout, busy, done
  );

  modport slave (
    input  req_valid, req_src, req_dst, req_use_ba,
    output req_ready, Rout, Rin, BAout, busy, done
  );
endinterface

// File: rtl/idx_to_onehot.sv
// Index-plus-enable to one-hot decoder; out-of-range indices decode to zero.
module idx_to_onehot #(
  parameter int NREGS = 16,
  parameter int IDXW  = 4
) (
  input  logic [IDXW-1:0]  idx,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (en && (32'(idx) == i)) onehot[i] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_xfer_sequencer.sv
// Sequences one register-to-register bus transfer per request, inserting
// settle cycles when R0 (registered output) is the source.
module bus_xfer_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int NREGS = NREGS_DEFAULT,
  parameter int IDXW  = IDXW_DEFAULT
) (
  input logic                  clk,
  input logic                  clr,
  bus_xfer_sequencer_if.slave  bus
);

  localparam logic [IDXW-1:0] R0 = IDXW'(R0_IDX);

  state_t           state, state_n;
  logic [IDXW-1:0]  src_q, dst_q;
  logic             use_ba_q;
  logic [1:0]       wait_cnt, wait_cnt_n;
  logic             r0_written;

  logic             accept;
  logic [IDXW-1:0]  src_sel;
  logic             ba_n;
  logic [NREGS-1:0] rout_n, rin_n;
  logic [NREGS-1:0] rout_q, rin_q;
  logic             ba_q, busy_q, done_q;

  assign bus.req_ready = (state == IDLE) && !clr;
  assign accept        = bus.req_valid && bus.req_ready;

  always_comb begin
    state_n    = state;
    wait_cnt_n = wait_cnt;
    case (state)
      IDLE:    if (accept) state_n = SETUP;
      SETUP: begin
        if (src_q != R0) begin
          state_n = CAPTURE;
        end else begin
          state_n    = WAIT;
          wait_cnt_n = 2'd1 + {1'b0, r0_written};
        end
      end
      WAIT: begin
        if (wait_cnt <= 2'd1) state_n = CAPTURE;
        else                  wait_cnt_n = wait_cnt - 2'd1;
      end
      CAPTURE: state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state; on the accepting edge the source
  // fields come straight from the request since the latches are not yet loaded.
  always_comb begin
    src_sel = accept ? bus.req_src : src_q;
    ba_n    = 1'b0;
    if (drives_bus(state_n)) begin
      ba_n = accept ? (bus.req_use_ba && (bus.req_src == R0))
                    : (use_ba_q && (src_q == R0));
    end
  end

  idx_to_onehot #(.NREGS(NREGS), .IDXW(IDXW)) u_rout_dec (
    .idx    (src_sel),
    .en     (drives_bus(state_n)),
    .onehot (rout_n)
  );

  idx_to_onehot #(.NREGS(NREGS), .IDXW(IDXW)) u_rin_dec (
    .idx    (dst_q),
    .en     (state_n == CAPTURE),
    .onehot (rin_n)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      r0_written <= 1'b0;
      src_q      <= '0;
      dst_q      <= '0;
      use_ba_q   <= 1'b0;
      rout_q     <= '0;
      rin_q      <= '0;
      ba_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
      if (accept) begin
        src_q    <= bus.req_src;
        dst_q    <= bus.req_dst;
        use_ba_q <= bus.req_use_ba;
      end
      if (state == CAPTURE) r0_written <= (dst_q == R0);
      rout_q <= rout_n;
      rin_q  <= rin_n;
      ba_q   <= ba_n;
      busy_q <= (state_n != IDLE);
      done_q <= (state_n == DONE);
    end
  end

  assign bus.Rout  = rout_q;
  assign bus.Rin   = rin_q;
  assign bus.BAout = ba_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Directed-vector bench for bus_xfer_sequencer with hand-computed expectations.
module tb_bus_xfer_sequencer;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec  = 0;
  int   n_miss = 0;

  always #5 clk = ~clk;

  bus_xfer_sequencer_if #(.NREGS(16), .IDXW(4)) bus ();

  bus_xfer_sequencer #(.NREGS(16), .IDXW(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Issue one request and check every cycle until done, then the return to IDLE.
  // lat = cycle index (first post-accept cycle is 1) in which done is high.
  task automatic run_xfer(input logic [3:0] src, input logic [3:0] dst, input logic use_ba,
                          input logic [15:0] exp_rout, input logic [15:0] exp_rin,
                          input logic exp_ba, input int lat);
    for (int i = 0; i < 20 && !bus.req_ready; i++) @(posedge clk) #1;
    check_vec("ready_before_accept", 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_src    = src;
    bus.req_dst    = dst;
    bus.req_use_ba = use_ba;
    @(posedge clk) #1;
    bus.req_valid  = 1'b0;
    bus.req_src    = 4'hF;
    bus.req_dst    = 4'hF;
    bus.req_use_ba = 1'b1;
    for (int n = 1; n <= lat; n++) begin
      check_vec("rout",  32'(bus.Rout),  (n < lat) ? 32'(exp_rout) : 32'd0);
      check_vec("rin",   32'(bus.Rin),   (n == lat - 1) ? 32'(exp_rin) : 32'd0);
      check_vec("baout", 32'(bus.BAout), (n < lat) ? 32'(exp_ba) : 32'd0);
      check_vec("done",  32'(bus.done),  (n == lat) ? 32'd1 : 32'd0);
      check_vec("busy",  32'(bus.busy),  32'd1);
      check_vec("ready_busy", 32'(bus.req_ready), 32'd0);
      @(posedge clk) #1;
    end
    check_vec("idle_busy",  32'(bus.busy),      32'd0);
    check_vec("idle_done",  32'(bus.done),      32'd0);
    check_vec("idle_rout",  32'(bus.Rout),      32'd0);
    check_vec("idle_ready", 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    bus.req_valid  = 1'b1;
    bus.req_src    = 4'd3;
    bus.req_dst    = 4'd5;
    bus.req_use_ba = 1'b1;
    clr = 1'b1;

    repeat (2) begin
      @(posedge clk) #1;
      check_vec("rst_ready", 32'(bus.req_ready), 32'd0);
      check_vec("rst_rout",  32'(bus.Rout),      32'd0);
      check_vec("rst_rin",   32'(bus.Rin),       32'd0);
      check_vec("rst_ba",    32'(bus.BAout),     32'd0);
      check_vec("rst_busy",  32'(bus.busy),      32'd0);
      check_vec("rst_done",  32'(bus.done),      32'd0);
    end
    bus.req_valid = 1'b0;
    clr = 1'b0;
    #1;
    check_vec("rel_ready", 32'(bus.req_ready), 32'd1);

    // Plain transfer, base-address read of R0, use_ba ignored for non-R0 source.
    run_xfer(4'd3, 4'd5, 1'b0, 16'h0008, 16'h0020, 1'b0, 3);
    run_xfer(4'd0, 4'd2, 1'b1, 16'h0001, 16'h0004, 1'b1, 4);
    run_xfer(4'd6, 4'd4, 1'b1, 16'h0040, 16'h0010, 1'b0, 3);

    // R0 written, then read immediately: two settle cycles.
    run_xfer(4'd7, 4'd0, 1'b0, 16'h0080, 16'h0001, 1'b0, 3);
    run_xfer(4'd0, 4'd1, 1'b0, 16'h0001, 16'h0002, 1'b0, 5);

    // Set the hazard flag, then abort an R0-source transfer in WAIT.
    run_xfer(4'd4, 4'd0, 1'b0, 16'h0010, 16'h0001, 1'b0, 3);
    bus.req_valid  = 1'b1;
    bus.req_src    = 4'd0;
    bus.req_dst    = 4'd3;
    bus.req_use_ba = 1'b1;
    @(posedge clk) #1;
    bus.req_valid = 1'b0;
    check_vec("abort_setup_rout", 32'(bus.Rout),  32'h0001);
    check_vec("abort_setup_ba",   32'(bus.BAout), 32'd1);
    @(posedge clk) #1;
    check_vec("abort_wait_rout", 32'(bus.Rout), 32'h0001);
    check_vec("abort_wait_busy", 32'(bus.busy), 32'd1);
    clr = 1'b1;
    @(posedge clk) #1;
    check_vec("abort_busy",  32'(bus.busy),      32'd0);
    check_vec("abort_rout",  32'(bus.Rout),      32'd0);
    check_vec("abort_rin",   32'(bus.Rin),       32'd0);
    check_vec("abort_ba",    32'(bus.BAout),     32'd0);
    check_vec("abort_done",  32'(bus.done),      32'd0);
    check_vec("abort_ready", 32'(bus.req_ready), 32'd0);
    clr = 1'b0;
    repeat (4) begin
      @(posedge clk) #1;
      check_vec("abort_no_done", 32'(bus.done), 32'd0);
      check_vec("abort_idle",    32'(bus.busy), 32'd0);
      check_vec("abort_no_rin",  32'(bus.Rin),  32'd0);
    end
    run_xfer(4'd0, 4'd6, 1'b0, 16'h0001, 16'h0040, 1'b0, 4);

    // Source equals destination.
    run_xfer(4'd9, 4'd9, 1'b0, 16'h0200, 16'h0200, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
